// File: rtl/fir_pkg.sv
// Shared types and widths for the 4-tap FIR sample feeder datapath.
package fir_pkg;

  localparam int SAMPLE_W = 8;
  localparam int COEF_W   = 3;
  localparam int NTAPS    = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [COEF_W-1:0]   coef_t;
  typedef coef_t [NTAPS-1:0]   coef_set_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, full/empty flags and an occupancy counter.
module fir_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_s, pop_s;

  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty  = (wptr_q == rptr_q);
  assign rdata  = mem_q[rptr_q[AW-1:0]];
  assign level  = level_q;
  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_s) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d                = wptr_q + (AW+1)'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// FIR front end: sample FIFO with one-pop-per-cycle output and a shadow/commit coefficient bank.
// Optional macro FIR_UNDERRUN_HOLD_EN: on underrun Din holds its last value instead of zero.
module fir_sample_feeder #(
  parameter int  DEPTH    = 8,
  parameter int  SAMPLE_W = 8,
  parameter int  COEF_W   = 3,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                run,
  output logic [SAMPLE_W-1:0] Din,
  output logic                din_real,
  output logic                underrun,
  output logic [LW-1:0]       level,
  input  logic                coef_we,
  input  logic [1:0]          coef_addr,
  input  logic [COEF_W-1:0]   coef_wdata,
  input  logic                coef_commit,
  output logic [COEF_W-1:0]   B0,
  output logic [COEF_W-1:0]   B1,
  output logic [COEF_W-1:0]   B2,
  output logic [COEF_W-1:0]   B3
);

  import fir_pkg::*;

  logic                           fifo_full_s, fifo_empty_s;
  logic [SAMPLE_W-1:0]            head_s;
  logic                           push_s, pop_s;
  logic                           ready_q, ready_d;
  logic [SAMPLE_W-1:0]            din_q, din_d;
  logic                           real_q, real_d;
  logic                           und_q, und_d;
  logic [NTAPS-1:0][COEF_W-1:0]   shadow_q, shadow_d;
  logic [NTAPS-1:0][COEF_W-1:0]   live_q, live_d;

  // ready_q keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_q && !fifo_full_s;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = run && !fifo_empty_s;

  fir_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset),
    .push  (push_s),
    .wdata (in_data),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (level)
  );

  always_comb begin
    ready_d = 1'b1;
    din_d   = '0;
    real_d  = 1'b0;
    und_d   = 1'b0;
    if (run) begin
      if (!fifo_empty_s) begin
        din_d  = head_s;
        real_d = 1'b1;
      end else begin
`ifdef FIR_UNDERRUN_HOLD_EN
        din_d = din_q;
`else
        din_d = '0;
`endif
        und_d = 1'b1;
      end
    end else begin
      din_d = '0;
    end
  end

  // A write on the commit edge is folded into the committed set.
  always_comb begin
    shadow_d = shadow_q;
    live_d   = live_q;
    if (coef_we) begin
      shadow_d[coef_addr] = coef_wdata;
    end else begin
      shadow_d = shadow_q;
    end
    if (coef_commit) begin
      live_d = shadow_d;
    end else begin
      live_d = live_q;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b0;
      din_q    <= '0;
      real_q   <= 1'b0;
      und_q    <= 1'b0;
      shadow_q <= '0;
      live_q   <= '0;
    end else begin
      ready_q  <= ready_d;
      din_q    <= din_d;
      real_q   <= real_d;
      und_q    <= und_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  assign Din      = din_q;
  assign din_real = real_q;
  assign underrun = und_q;
  assign B0       = live_q[0];
  assign B1       = live_q[1];
  assign B2       = live_q[2];
  assign B3       = live_q[3];

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboard bench for fir_sample_feeder: directed stimulus, queue-based monitor on din_real.
module tb_fir_sample_feeder;

  localparam int DEPTH = 8;

  logic       CLK;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       run;
  logic [7:0] Din;
  logic       din_real;
  logic       underrun;
  logic [3:0] level;
  logic       coef_we;
  logic [1:0] coef_addr;
  logic [2:0] coef_wdata;
  logic       coef_commit;
  logic [2:0] B0, B1, B2, B3;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [$];
  logic [7:0] mdl_q [$];
  int         mdl_level = 0;
  logic [7:0] mdl_din = 8'h00;
  logic [2:0] mdl_shadow [4];
  logic [2:0] mdl_live [4];

  fir_sample_feeder #(.DEPTH(DEPTH), .SAMPLE_W(8), .COEF_W(3)) dut (
    .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .run(run), .Din(Din), .din_real(din_real),
    .underrun(underrun), .level(level), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every real sample on Din must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (reset && din_real) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", Din);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (Din != e) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", Din, e);
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit r);
    bit push, pop, exp_real, exp_und;
    in_valid = v;
    in_data  = d;
    run      = r;
    chk("in_ready", int'(in_ready), int'(mdl_level < DEPTH));
    push = v && (mdl_level < DEPTH);
    pop  = r && (mdl_level > 0);
    @(posedge CLK);
    if (push) begin
      exp_q.push_back(d);
      mdl_q.push_back(d);
    end
    if (pop) begin
      mdl_din  = mdl_q.pop_front();
      exp_real = 1'b1;
      exp_und  = 1'b0;
    end else if (r) begin
`ifndef FIR_UNDERRUN_HOLD_EN
      mdl_din = 8'h00;
`endif
      exp_real = 1'b0;
      exp_und  = 1'b1;
    end else begin
      mdl_din  = 8'h00;
      exp_real = 1'b0;
      exp_und  = 1'b0;
    end
    mdl_level = mdl_level + int'(push) - int'(pop);
    @(negedge CLK);
    chk("din_real", int'(din_real), int'(exp_real));
    chk("underrun", int'(underrun), int'(exp_und));
    chk("level", int'(level), mdl_level);
    chk("din", int'(Din), int'(mdl_din));
  endtask

  task automatic coef_step(input bit we, input logic [1:0] a, input logic [2:0] w, input bit c);
    coef_we     = we;
    coef_addr   = a;
    coef_wdata  = w;
    coef_commit = c;
    @(posedge CLK);
    if (we) mdl_shadow[a] = w;
    if (c) for (int i = 0; i < 4; i++) mdl_live[i] = mdl_shadow[i];
    @(negedge CLK);
    coef_we     = 1'b0;
    coef_commit = 1'b0;
    chk("B0", int'(B0), int'(mdl_live[0]));
    chk("B1", int'(B1), int'(mdl_live[1]));
    chk("B2", int'(B2), int'(mdl_live[2]));
    chk("B3", int'(B3), int'(mdl_live[3]));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mdl_shadow[i] = 3'd0;
      mdl_live[i]   = 3'd0;
    end
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; run = 1'b0;
    coef_we = 1'b0; coef_addr = 2'd0; coef_wdata = 3'd0; coef_commit = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_din", int'(Din), 0);
    chk("rst_B", int'({B0, B1, B2, B3}), 0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("rel_in_ready", int'(in_ready), 1);

    // Fill to full with run low, then attempt a ninth push.
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'h09, 1'b0);
    // Drain, then one underrun.
    for (int i = 0; i < 9; i++) drive(1'b0, 8'h00, 1'b1);

    // Streaming with run high.
    drive(1'b1, 8'h10, 1'b1);
    drive(1'b1, 8'h20, 1'b1);
    drive(1'b1, 8'h30, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    // Underrun after a 0x5A sample.
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);

    // Wrap-around streaming.
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    // Coefficients.
    in_valid = 1'b0; run = 1'b0;
    coef_step(1'b1, 2'd0, 3'd1, 1'b0);
    coef_step(1'b1, 2'd1, 3'd2, 1'b0);
    coef_step(1'b1, 2'd2, 3'd3, 1'b0);
    coef_step(1'b1, 2'd3, 3'd4, 1'b0);
    coef_step(1'b1, 2'd3, 3'd7, 1'b1);
    chk("coef_final", int'({B0, B1, B2, B3}), int'({3'd1, 3'd2, 3'd3, 3'd7}));

    // Reset mid-stream with level 5 and a real sample on Din.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    in_valid = 1'b0; run = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_din", int'(Din), 0);
    chk("mid_rst_B", int'({B0, B1, B2, B3}), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    exp_q.delete();
    mdl_q.delete();
    mdl_level = 0;
    mdl_din   = 8'h00;
    for (int i = 0; i < 4; i++) begin
      mdl_shadow[i] = 3'd0;
      mdl_live[i]   = 3'd0;
    end
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", int'(in_ready), 1);
    drive(1'b1, 8'h77, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
